collatz_engine: RTL and testbench

COLLATZ_ENGINE -- requirements
Module: collatz_engine

---
 rtl/collatz_pkg.sv | 13 +
 rtl/collatz_step.sv | 26 ++
 rtl/collatz_engine.sv | 89 ++++++++
 tb/tb_collatz_engine.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/collatz_pkg.sv
// rtl/collatz_pkg.sv - shared state encoding and default widths for the collatz engine
package collatz_pkg;

    localparam int N_BITS_DEF = 32;
    localparam int C_BITS_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/collatz_step.sv
// rtl/collatz_step.sv - combinational single collatz step with 3n+1 overflow detection
module collatz_step
    import collatz_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
) (
    input  logic [N_BITS-1:0] n,
    output logic [N_BITS-1:0] n_next,
    output logic              overflow
);

    // 3n+1 is formed two bits wider so the carry out of N_BITS is visible
    logic [N_BITS+1:0] triple;

    // even values halve, odd values take 3n+1 and flag any bits beyond N_BITS
    always_comb begin
        triple   = {2'b00, n} + {1'b0, n, 1'b0} + (N_BITS + 2)'(1);
        n_next   = n >> 1;
        overflow = 1'b0;
        if (n[0]) begin
            n_next   = triple[N_BITS-1:0];
            overflow = |triple[N_BITS+1:N_BITS];
        end
    end

endmodule

// File: rtl/collatz_engine.sv
// rtl/collatz_engine.sv - iterative collatz sequence-length engine, one step per cycle
module collatz_engine
    import collatz_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF,
    parameter int C_BITS = C_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [N_BITS-1:0] n_in,
    input  logic              abort,
    output logic              ready,
    output logic              done,
    output logic [C_BITS-1:0] count,
    output logic              overflow,
    output logic              saturated
);

    state_t            state;
    logic [N_BITS-1:0] n_reg;
    logic [N_BITS-1:0] n_next;
    logic              step_ovf;

    collatz_step #(
        .N_BITS(N_BITS)
    ) u_step (
        .n       (n_reg),
        .n_next  (n_next),
        .overflow(step_ovf)
    );

    // control FSM with registered ready/done; abort outranks every termination check
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            n_reg     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            saturated <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        n_reg     <= n_in;
                        // a zero start value has no terms, so it reports zero length
                        count     <= (n_in == '0) ? '0 : C_BITS'(1);
                        overflow  <= 1'b0;
                        saturated <= 1'b0;
                        state     <= ST_RUN;
                        ready     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                    end else if (n_reg <= N_BITS'(1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (&count) begin
                        saturated <= 1'b1;
                        state     <= ST_DONE;
                        done      <= 1'b1;
                    end else if (step_ovf) begin
                        overflow <= 1'b1;
                        state    <= ST_DONE;
                        done     <= 1'b1;
                    end else begin
                        n_reg <= n_next;
                        count <= count + C_BITS'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collatz_engine.sv
// tb/tb_collatz_engine.sv - scoreboard bench for collatz_engine
module tb_collatz_engine;

    typedef struct {
        int cnt;
        bit ovf;
        bit sat;
        int lat;
        int acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [31:0] n_in = '0;
    logic        abort = 1'b0;
    logic        ready, done, overflow, saturated;
    logic [15:0] count;

    logic        go4 = 1'b0;
    logic [31:0] n4 = '0;
    logic        abort4 = 1'b0;
    logic        ready4, done4, overflow4, saturated4;
    logic [3:0]  count4;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t sb4[$];

    collatz_engine #(.N_BITS(32), .C_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .n_in(n_in), .abort(abort),
        .ready(ready), .done(done), .count(count),
        .overflow(overflow), .saturated(saturated)
    );

    collatz_engine #(.N_BITS(32), .C_BITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .go(go4), .n_in(n4), .abort(abort4),
        .ready(ready4), .done(done4), .count(count4),
        .overflow(overflow4), .saturated(saturated4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    // monitor for the 16-bit counter instance
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", count, -1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("count", count, e.cnt);
                chk("overflow", overflow, e.ovf);
                chk("saturated", saturated, e.sat);
                chk("latency", cyc - e.acc, e.lat);
                chk("ready_during_done", ready, 0);
            end
        end
    end

    // monitor for the 4-bit counter instance
    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (sb4.size() == 0) begin
                chk("spurious_done4", count4, -1);
            end else begin
                exp_t e;
                e = sb4.pop_front();
                chk("count4", count4, e.cnt);
                chk("overflow4", overflow4, e.ovf);
                chk("saturated4", saturated4, e.sat);
                chk("latency4", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic start(input logic [31:0] n, output int acc);
        int t = 0;
        while (!ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (!ready) chk("ready_wait", ready, 1);
        go = 1'b1;
        n_in = n;
        @(posedge clk); #1;
        acc = cyc;
        go = 1'b0;
        n_in = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || sb4.size() != 0) && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("drain", sb.size() + sb4.size(), 0);
    endtask

    task automatic run_vec(input logic [31:0] n, input int cnt, input bit ovf, input bit sat, input int lat);
        int acc;
        start(n, acc);
        sb.push_back('{cnt: cnt, ovf: ovf, sat: sat, lat: lat, acc: acc});
        drain();
        repeat (3) @(negedge clk);
        chk("held_count", count, cnt);
        chk("held_overflow", overflow, ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle=%0d required=finish", cyc);
        $fatal(1);
    end

    initial begin
        int acc;
        int t;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_saturated", saturated, 0);

        run_vec(32'd3, 8, 0, 0, 8);
        run_vec(32'd1, 1, 0, 0, 1);
        run_vec(32'd0, 0, 0, 0, 1);
        run_vec(32'd27, 112, 0, 0, 112);
        run_vec(32'hFFFF_FFFF, 1, 1, 0, 1);
        run_vec(32'd7, 17, 0, 0, 17);

        // saturation on the narrow counter
        @(posedge clk); #1;
        go4 = 1'b1;
        n4 = 32'd27;
        @(posedge clk); #1;
        acc = cyc;
        go4 = 1'b0;
        sb4.push_back('{cnt: 15, ovf: 0, sat: 1, lat: 15, acc: acc});
        drain();

        // abort sampled on the tenth edge after accept
        start(32'd27, acc);
        repeat (9) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        chk("abort_count", count, 10);
        repeat (5) @(negedge clk);
        run_vec(32'd6, 9, 0, 0, 9);

        // go held high through RUN and DONE yields exactly one result
        @(posedge clk); #1;
        go = 1'b1;
        n_in = 32'd3;
        @(posedge clk); #1;
        acc = cyc;
        sb.push_back('{cnt: 8, ovf: 0, sat: 0, lat: 8, acc: acc});
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 100);
        @(posedge clk); #1;
        go = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        chk("held_go_ready", ready, 1);
        chk("held_go_count", count, 8);

        // reset mid-run with go asserted discards the computation
        start(32'd27, acc);
        repeat (20) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        go = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        go = 1'b0;
        @(negedge clk);
        chk("midrst_ready", ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_count", count, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_saturated", saturated, 0);
        repeat (150) @(negedge clk);
        chk("final_queue", sb.size() + sb4.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
